// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes, FSM state type,
// and the byte-enable / alignment helpers used on the request path.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, RUN} mem_state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] byte_off);
        logic [3:0] be;
        be = '0;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << byte_off;
            F3_H, F3_HU: be = 4'b0011 << byte_off;
            F3_W:        be = 4'hF;
            default:     be = '0;
        endcase
        return be;
    endfunction

    // Codes 011/110/111 fall into default and are reported as misaligned.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~byte_off[0];
            F3_W:        ok = (byte_off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extender.sv
// Selects the addressed byte/half lane of a registered read word and sign- or zero-extends it.
module load_extender
    import mem_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      byte_off_i,
    output logic [SIZE-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[8*byte_off_i +: 8];
    assign half_lane = word_i[16*byte_off_i[1] +: 16];

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_B:    data_o = {{(SIZE-8){byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {{(SIZE-8){1'b0}}, byte_lane};
            F3_H:    data_o = {{(SIZE-16){half_lane[15]}}, half_lane};
            F3_HU:   data_o = {{(SIZE-16){1'b0}}, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined core: byte-lane RAM with RV32I sized stores,
// 1-cycle registered extended loads, misalignment reporting and an optional post-reset clear sweep.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int SIZE           = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            funct3,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [SIZE-1:0]       ddata_w,
    output logic [SIZE-1:0]       ddata_r,
    output logic                  rvalid,
    output logic                  misaligned,
    output logic                  ready
);

    localparam int unsigned          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0][7:0]       mem_q [DEPTH];

    logic [SIZE-1:0] rd_word_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            rvalid_q;
    logic            mis_q;

    logic            aligned;
    logic            load_acc;
    logic            store_acc;
    logic            bad_acc;
    logic            clr_we;
    logic [3:0]      be;
    logic [SIZE-1:0] wdata;

    assign ready     = RESET_N && (state_q == RUN);
    assign aligned   = is_aligned(funct3, byte_off);
    assign be        = byte_enable(funct3, byte_off);
    assign load_acc  = ready && MemRead && aligned;
    assign store_acc = ready && MemWrite && aligned;
    assign bad_acc   = ready && (MemRead || MemWrite) && !aligned;
    // Gated by RESET_N so holding reset never disturbs RAM contents.
    assign clr_we    = RESET_N && (state_q == CLEAR);

    always_comb begin
        wdata = ddata_w;
        case (funct3)
            F3_B, F3_BU: wdata = {4{ddata_w[7:0]}};
            F3_H, F3_HU: wdata = {2{ddata_w[15:0]}};
            default:     wdata = ddata_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            if (CLEAR_ON_RESET) begin
                state_q <= CLEAR;
            end else begin
                state_q <= RUN;
            end
            cnt_q     <= '0;
            rd_word_q <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            rvalid_q  <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= load_acc;
            mis_q    <= bad_acc;
            // Read samples the pre-store word when a store hits the same edge.
            if (load_acc) begin
                rd_word_q <= mem_q[daddr];
                f3_q      <= funct3;
                off_q     <= byte_off;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (store_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[daddr][i] <= wdata[8*i +: 8];
                end
            end
        end
    end

    load_extender #(
        .SIZE(SIZE)
    ) u_load_extender (
        .word_i     (rd_word_q),
        .funct3_i   (f3_q),
        .byte_off_i (off_q),
        .data_o     (ddata_r)
    );

    assign rvalid     = rvalid_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: clear sweep, sized loads/stores, misalignment,
// read-before-write, back-to-back loads and reset during the sweep.
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  daddr = '0;
    logic [1:0]  byte_off = '0;
    logic [2:0]  funct3 = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ddata_w = '0;
    logic [31:0] ddata_r;
    logic        rvalid;
    logic        misaligned;
    logic        ready;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .SIZE(32),
        .ADDR_WIDTH(10),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .daddr(daddr),
        .byte_off(byte_off),
        .funct3(funct3),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .ddata_w(ddata_w),
        .ddata_r(ddata_r),
        .rvalid(rvalid),
        .misaligned(misaligned),
        .ready(ready)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [1:0] off, input logic [2:0] f3, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; daddr = a; byte_off = off; funct3 = f3; ddata_w = d;
        step();
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Releases reset and counts cycles until ready; requests are driven throughout and must be ignored.
    task automatic sweep(input bit mis_req, output int n, output bit leak);
        n = 0;
        leak = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b1; daddr = 10'd0; ddata_w = 32'hDEAD_BEEF;
        funct3 = mis_req ? 3'b001 : 3'b010;
        byte_off = mis_req ? 2'd1 : 2'd0;
        RESET_N = 1'b1;
        while (n < 2000) begin
            step();
            n++;
            if (rvalid !== 1'b0 || misaligned !== 1'b0) leak = 1'b1;
            if (ready === 1'b1) break;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        bit leak;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || misaligned !== 1'b0 || ddata_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b mis=%b ddata_r=%h, want 0/0/0/00000000",
                     ready, rvalid, misaligned, ddata_r);
        end
        sweep(1'b0, n, leak);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL sweep_len: got %0d cycles, want 1024", n);
        end
        checks++;
        if (leak !== 1'b0) begin
            errors++;
            $display("FAIL sweep_ignore: rvalid/misaligned seen during sweep, want none");
        end
        for (int i = 0; i < 3; i++) begin
            logic [9:0] a;
            a = (i == 0) ? 10'd0 : (i == 1) ? 10'd3 : 10'd1023;
            access(1'b1, 1'b0, a, 2'd0, 3'b010, 32'h0);
            checks++;
            if (ddata_r !== 32'h0 || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL cleared_lw[%0d]: ddata_r=%h rvalid=%b, want 00000000/1", a, ddata_r, rvalid);
            end
        end
    endtask

    task automatic test_sign_ext();
        access(1'b0, 1'b1, 10'd5, 2'd0, 3'b010, 32'h8000_00F1);
        access(1'b1, 1'b0, 10'd5, 2'd0, 3'b000, 32'h0);
        checks++;
        if (ddata_r !== 32'hFFFF_FFF1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL lb_off0: ddata_r=%h rvalid=%b, want fffffff1/1", ddata_r, rvalid);
        end
        access(1'b1, 1'b0, 10'd5, 2'd0, 3'b100, 32'h0);
        checks++;
        if (ddata_r !== 32'h0000_00F1) begin
            errors++;
            $display("FAIL lbu_off0: ddata_r=%h, want 000000f1", ddata_r);
        end
        access(1'b1, 1'b0, 10'd5, 2'd2, 3'b001, 32'h0);
        checks++;
        if (ddata_r !== 32'hFFFF_8000) begin
            errors++;
            $display("FAIL lh_off2: ddata_r=%h, want ffff8000", ddata_r);
        end
        access(1'b1, 1'b0, 10'd5, 2'd2, 3'b101, 32'h0);
        checks++;
        if (ddata_r !== 32'h0000_8000) begin
            errors++;
            $display("FAIL lhu_off2: ddata_r=%h, want 00008000", ddata_r);
        end
        access(1'b1, 1'b0, 10'd5, 2'd3, 3'b000, 32'h0);
        checks++;
        if (ddata_r !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_off3: ddata_r=%h, want ffffff80", ddata_r);
        end
    endtask

    task automatic test_byte_stores();
        access(1'b0, 1'b1, 10'd7, 2'd3, 3'b000, 32'h0000_00AA);
        access(1'b1, 1'b0, 10'd7, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'hAA00_0000) begin
            errors++;
            $display("FAIL sb_off3: ddata_r=%h, want aa000000", ddata_r);
        end
        access(1'b0, 1'b1, 10'd7, 2'd2, 3'b001, 32'h0000_1234);
        access(1'b1, 1'b0, 10'd7, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'h1234_0000) begin
            errors++;
            $display("FAIL sh_off2: ddata_r=%h, want 12340000", ddata_r);
        end
        access(1'b0, 1'b1, 10'd8, 2'd1, 3'b000, 32'hFFFF_FF55);
        access(1'b1, 1'b0, 10'd8, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'h0000_5500) begin
            errors++;
            $display("FAIL sb_off1_upper_ignored: ddata_r=%h, want 00005500", ddata_r);
        end
    endtask

    task automatic test_misaligned();
        access(1'b0, 1'b1, 10'd9, 2'd0, 3'b010, 32'hCAFE_BABE);
        access(1'b1, 1'b0, 10'd9, 2'd0, 3'b010, 32'h0);
        access(1'b0, 1'b1, 10'd9, 2'd1, 3'b001, 32'h0000_1111);
        checks++;
        if (misaligned !== 1'b1 || rvalid !== 1'b0 || ddata_r !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL sh_off1: mis=%b rvalid=%b ddata_r=%h, want 1/0/cafebabe", misaligned, rvalid, ddata_r);
        end
        step();
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: mis=%b, want 0", misaligned);
        end
        access(1'b0, 1'b1, 10'd9, 2'd2, 3'b010, 32'h0000_0000);
        checks++;
        if (misaligned !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL sw_off2: mis=%b rvalid=%b, want 1/0", misaligned, rvalid);
        end
        access(1'b1, 1'b0, 10'd9, 2'd0, 3'b011, 32'h0);
        checks++;
        if (misaligned !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_f3: mis=%b rvalid=%b, want 1/0", misaligned, rvalid);
        end
        access(1'b1, 1'b0, 10'd9, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'hCAFE_BABE || rvalid !== 1'b1 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_no_write: ddata_r=%h rvalid=%b mis=%b, want cafebabe/1/0", ddata_r, rvalid, misaligned);
        end
    endtask

    task automatic test_rmw();
        access(1'b0, 1'b1, 10'd12, 2'd0, 3'b010, 32'h0000_0011);
        access(1'b1, 1'b1, 10'd12, 2'd0, 3'b010, 32'h0000_0022);
        checks++;
        if (ddata_r !== 32'h0000_0011 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rbw_old: ddata_r=%h rvalid=%b, want 00000011/1", ddata_r, rvalid);
        end
        access(1'b1, 1'b0, 10'd12, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'h0000_0022) begin
            errors++;
            $display("FAIL rbw_new: ddata_r=%h, want 00000022", ddata_r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0123_4567; vals[1] = 32'h89AB_CDEF;
        vals[2] = 32'hFEDC_BA98; vals[3] = 32'h7654_3210;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 10'(20 + i), 2'd0, 3'b010, vals[i]);
        end
        MemRead = 1'b1; funct3 = 3'b010; byte_off = 2'd0;
        for (int i = 0; i < 4; i++) begin
            daddr = 10'(20 + i);
            step();
            checks++;
            if (ddata_r !== vals[i] || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: ddata_r=%h rvalid=%b, want %h/1", i, ddata_r, rvalid, vals[i]);
            end
        end
        MemRead = 1'b0;
        step();
        checks++;
        if (rvalid !== 1'b0 || ddata_r !== 32'h7654_3210) begin
            errors++;
            $display("FAIL hold_after_b2b: rvalid=%b ddata_r=%h, want 0/76543210", rvalid, ddata_r);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        bit leak;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (ddata_r !== 32'h0 || rvalid !== 1'b0 || ready !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ddata_r=%h rvalid=%b ready=%b mis=%b, want 0/0/0/0",
                     ddata_r, rvalid, ready, misaligned);
        end
        step();
        RESET_N = 1'b1;
        repeat (500) step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_ready: ready=%b, want 0", ready);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || ddata_r !== 32'h0) begin
            errors++;
            $display("FAIL mid_sweep_reset: ready=%b rvalid=%b ddata_r=%h, want 0/0/0", ready, rvalid, ddata_r);
        end
        step();
        sweep(1'b1, n, leak);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL restart_sweep_len: got %0d cycles, want 1024", n);
        end
        checks++;
        if (leak !== 1'b0) begin
            errors++;
            $display("FAIL restart_sweep_ignore: rvalid/misaligned seen during sweep, want none");
        end
        access(1'b1, 1'b0, 10'd12, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'h0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL recleared_word12: ddata_r=%h rvalid=%b, want 00000000/1", ddata_r, rvalid);
        end
        access(1'b1, 1'b0, 10'd21, 2'd0, 3'b010, 32'h0);
        checks++;
        if (ddata_r !== 32'h0) begin
            errors++;
            $display("FAIL recleared_word21: ddata_r=%h, want 00000000", ddata_r);
        end
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_byte_stores();
        test_misaligned();
        test_rmw();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
